// File: rtl/tx_link_sched_pkg.sv
// Shared encodings and limits for the DS transmit scheduler.
package tx_link_sched_pkg;

  typedef enum logic [1:0] {
    S_OFF        = 2'd0,
    S_STARTED    = 2'd1,
    S_CONNECTING = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  localparam int CREDIT_MAX = 56;
  localparam int FCT_CHUNK  = 8;
  localparam int OWED_MAX   = 7;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/tx_credit_ctr.sv
// Transmit credit counter: +FCT_CHUNK per grant, -1 per data ack, sticky overflow flag, clear on OFF.
module tx_credit_ctr
  import tx_link_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       grant,
  input  logic       take,
  output logic [5:0] credit,
  output logic [5:0] credit_nxt,
  output logic       err
);

  logic [6:0] sum;
  logic [5:0] base;
  logic       ovf;

  // Overflow is judged on the pre-decrement value, so a dropped grant still lets the decrement through.
  always_comb begin
    sum        = {1'b0, credit} + 7'(FCT_CHUNK);
    ovf        = grant && (sum > 7'(CREDIT_MAX));
    base       = (grant && !ovf) ? sum[5:0] : credit;
    credit_nxt = base;
    if (take && credit != 6'd0) credit_nxt = base - 6'd1;
    if (clr) credit_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
      err    <= 1'b0;
    end else begin
      credit <= credit_nxt;
      err    <= !clr && (err || ovf);
    end
  end

endmodule

// File: rtl/tx_link_sched.sv
// Transmit scheduler for the DS character selector: link sequencing, credit, owed FCTs, time-codes.
// Optional statistics counters are built when TX_LINK_SCHED_STATS_EN is defined.
module tx_link_sched
  import tx_link_sched_pkg::*;
(
  input  logic             txClk,
  input  logic             txReset,
  input  logic             linkEnable_i,
  input  logic             gotNull_i,
  input  logic             fctRcvd_i,
  input  logic             rxSpaceFreed_i,
  input  logic             tickIn_i,
  input  logic             fifoEmpty_i,
  input  logic             ackTimecode_i,
  input  logic             ackSpaceAvail_i,
  input  logic             ackData_i,
  input  logic             ackIdle_i,
  output logic             reqTimecode_o,
  output logic             reqSpaceAvail_o,
  output logic             reqData_o,
  output logic             reqIdle_o,
  output logic             fifoPop_o,
  output logic [1:0]       state_o,
  output logic [5:0]       credit_o,
  output logic             creditErr_o,
  output logic             tickOverrun_o
`ifdef TX_LINK_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] dataSent_o,
  output logic [STAT_W-1:0] fctSent_o
`endif
);

  state_t     state, state_nxt;
  logic       live, clr, grant, take, ack_sa, ack_tc;
  logic [2:0] owed, owed_nxt;
  logic       pend, pend_nxt, tick_run, overrun;
  logic [5:0] credit_nxt;

  // The idle ack carries no state: reqIdle_o follows the link state alone.
  logic unused_ack_idle;
  assign unused_ack_idle = ackIdle_i;

  always_ff @(posedge txClk) begin
    if (txReset) state <= S_OFF;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:        if (linkEnable_i) state_nxt = S_STARTED;
      S_STARTED:    if (gotNull_i)    state_nxt = S_CONNECTING;
      S_CONNECTING: if (fctRcvd_i)    state_nxt = S_RUN;
      default:      ;
    endcase
    if (!linkEnable_i) state_nxt = S_OFF;
  end

  // Everything is held cleared while OFF and on the way into it; acks seen in OFF are dropped here.
  always_comb begin
    live   = (state != S_OFF);
    clr    = !linkEnable_i || !live;
    grant  = fctRcvd_i && (state == S_CONNECTING || state == S_RUN);
    take   = ackData_i && live;
    ack_sa = ackSpaceAvail_i && live;
    ack_tc = ackTimecode_i && live;
  end

  tx_credit_ctr u_credit (
    .clk        (txClk),
    .rst        (txReset),
    .clr        (clr),
    .grant      (grant),
    .take       (take),
    .credit     (credit_o),
    .credit_nxt (credit_nxt),
    .err        (creditErr_o)
  );

  always_comb begin
    owed_nxt = owed;
    if (rxSpaceFreed_i && !ack_sa && owed != 3'(OWED_MAX)) owed_nxt = owed + 3'd1;
    else if (ack_sa && !rxSpaceFreed_i && owed != 3'd0)    owed_nxt = owed - 3'd1;
    if (clr) owed_nxt = '0;
  end

  // A tick landing on the same cycle as the ack of the previous one replaces it rather than overrunning.
  always_comb begin
    tick_run = tickIn_i && (state == S_RUN);
    overrun  = tick_run && pend && !ack_tc;
    pend_nxt = !clr && (tick_run || (pend && !ack_tc));
  end

  // Requests are computed from next-cycle values so they line up with the state/credit they reflect.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      owed            <= '0;
      pend            <= 1'b0;
      reqIdle_o       <= 1'b0;
      reqSpaceAvail_o <= 1'b0;
      reqData_o       <= 1'b0;
      reqTimecode_o   <= 1'b0;
      fifoPop_o       <= 1'b0;
      tickOverrun_o   <= 1'b0;
    end else begin
      owed            <= owed_nxt;
      pend            <= pend_nxt;
      reqIdle_o       <= (state_nxt != S_OFF);
      reqSpaceAvail_o <= (owed_nxt != 3'd0) && (state_nxt == S_CONNECTING || state_nxt == S_RUN);
      reqData_o       <= (state_nxt == S_RUN) && (credit_nxt != 6'd0) && !fifoEmpty_i;
      reqTimecode_o   <= (state_nxt == S_RUN) && pend_nxt;
      fifoPop_o       <= take;
      tickOverrun_o   <= overrun;
    end
  end

  assign state_o = state;

`ifdef TX_LINK_SCHED_STATS_EN
  always_ff @(posedge txClk) begin
    if (txReset) begin
      dataSent_o <= '0;
      fctSent_o  <= '0;
    end else begin
      if (take)   dataSent_o <= dataSent_o + STAT_W'(1);
      if (ack_sa) fctSent_o  <= fctSent_o + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tx_link_sched.sv
// Bench for tx_link_sched: directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_tx_link_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, gnull, fct, space, tick, fempty, ack_t, ack_s, ack_d, ack_i;
  logic req_t, req_s, req_d, req_i, pop, cerr, ovr;
  logic [1:0] st;
  logic [5:0] cred;
`ifdef TX_LINK_SCHED_STATS_EN
  logic [15:0] dsent, fsent;
`endif

  int total = 0;
  int bad   = 0;

  // Model state, stepped once per clock from the rules of the link scheduler.
  int m_state = 0, m_credit = 0, m_owed = 0, m_pend = 0, m_err = 0, m_dsent = 0, m_fsent = 0;
  bit e_reqi, e_reqs, e_reqd, e_reqt, e_pop, e_ovr;

  tx_link_sched dut (
    .txClk           (clk),
    .txReset         (rst),
    .linkEnable_i    (en),
    .gotNull_i       (gnull),
    .fctRcvd_i       (fct),
    .rxSpaceFreed_i  (space),
    .tickIn_i        (tick),
    .fifoEmpty_i     (fempty),
    .ackTimecode_i   (ack_t),
    .ackSpaceAvail_i (ack_s),
    .ackData_i       (ack_d),
    .ackIdle_i       (ack_i),
    .reqTimecode_o   (req_t),
    .reqSpaceAvail_o (req_s),
    .reqData_o       (req_d),
    .reqIdle_o       (req_i),
    .fifoPop_o       (pop),
    .state_o         (st),
    .credit_o        (cred),
    .creditErr_o     (cerr),
    .tickOverrun_o   (ovr)
`ifdef TX_LINK_SCHED_STATS_EN
    ,
    .dataSent_o      (dsent),
    .fctSent_o       (fsent)
`endif
  );

  task automatic step();
    int ns, nc, no, np, ne;
    bit off;
    off = (m_state == 0);
    ns  = m_state;
    case (m_state)
      0: if (en)    ns = 1;
      1: if (gnull) ns = 2;
      2: if (fct)   ns = 3;
      default: ;
    endcase
    if (!en) ns = 0;
    nc = m_credit; no = m_owed; np = m_pend; ne = m_err;
    e_ovr = 0;
    e_pop = ack_d && !off;
    if (fct && m_state >= 2) begin
      if (m_credit + 8 > 56) ne = 1;
      else nc = nc + 8;
    end
    if (ack_d && !off && m_credit > 0) nc = nc - 1;
    if (!off) begin
      if (space && !ack_s) no = (m_owed < 7) ? m_owed + 1 : 7;
      else if (ack_s && !space && m_owed > 0) no = m_owed - 1;
      if (ack_t) np = 0;
      if (tick && m_state == 3) begin
        if (m_pend != 0 && !ack_t) e_ovr = 1;
        else np = 1;
      end
      if (ack_d) m_dsent = (m_dsent + 1) % 65536;
      if (ack_s) m_fsent = (m_fsent + 1) % 65536;
    end
    if (!en || off) begin nc = 0; no = 0; np = 0; ne = 0; end
    e_reqi = (ns != 0);
    e_reqs = (no != 0) && (ns >= 2);
    e_reqd = (ns == 3) && (nc != 0) && !fempty;
    e_reqt = (ns == 3) && (np != 0);
    if (rst) begin
      ns = 0; nc = 0; no = 0; np = 0; ne = 0; m_dsent = 0; m_fsent = 0;
      e_reqi = 0; e_reqs = 0; e_reqd = 0; e_reqt = 0; e_pop = 0; e_ovr = 0;
    end
    @(posedge clk); #1;
    m_state = ns; m_credit = nc; m_owed = no; m_pend = np; m_err = ne;
    gnull = 0; fct = 0; space = 0; tick = 0; ack_t = 0; ack_s = 0; ack_d = 0; ack_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; fempty = 0;
    gnull = 0; fct = 0; space = 0; tick = 0; ack_t = 0; ack_s = 0; ack_d = 0; ack_i = 0;
    step(); step();
    rst = 0;
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got %0d want 0", st); end
    total++; if (cred !== 6'd0) begin bad++; $display("FAIL reset_credit got %0d want 0", cred); end
    total++; if ({req_t, req_s, req_d, req_i, pop, cerr, ovr} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs got %b want 0000000", {req_t, req_s, req_d, req_i, pop, cerr, ovr});
    end
  endtask

  task automatic test_bringup();
    en = 1; step();
    total++; if (st !== 2'd1) begin bad++; $display("FAIL bringup_started got %0d want 1", st); end
    total++; if (req_i !== 1'b1) begin bad++; $display("FAIL bringup_reqidle got %b want 1", req_i); end
    gnull = 1; step();
    total++; if (st !== 2'd2) begin bad++; $display("FAIL bringup_connecting got %0d want 2", st); end
    fct = 1; step();
    total++; if (st !== 2'd3) begin bad++; $display("FAIL bringup_run got %0d want 3", st); end
    total++; if (cred !== 6'd8) begin bad++; $display("FAIL bringup_credit got %0d want 8", cred); end
    total++; if (req_d !== 1'b1) begin bad++; $display("FAIL bringup_reqdata got %b want 1", req_d); end
  endtask

  task automatic test_data_drain();
    int pops = 0;
    repeat (8) begin ack_d = 1; step(); if (pop === 1'b1) pops++; end
    total++; if (cred !== 6'd0) begin bad++; $display("FAIL drain_credit got %0d want 0", cred); end
    total++; if (req_d !== 1'b0) begin bad++; $display("FAIL drain_reqdata got %b want 0", req_d); end
    total++; if (pops != 8) begin bad++; $display("FAIL drain_pops got %0d want 8", pops); end
    step();
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL drain_pop_idle got %b want 0", pop); end
  endtask

  task automatic test_credit_overflow();
    repeat (7) begin fct = 1; step(); end
    total++; if (cred !== 6'd56) begin bad++; $display("FAIL ovf_credit_full got %0d want 56", cred); end
    total++; if (cerr !== 1'b0) begin bad++; $display("FAIL ovf_err_early got %b want 0", cerr); end
    fct = 1; step();
    total++; if (cerr !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", cerr); end
    total++; if (cred !== 6'd56) begin bad++; $display("FAIL ovf_credit_held got %0d want 56", cred); end
    repeat (8) begin ack_d = 1; step(); end
    fct = 1; ack_d = 1; step();
    total++; if (cred !== 6'd55) begin bad++; $display("FAIL ovf_fct_plus_ack got %0d want 55", cred); end
    total++; if (cerr !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got %b want 1", cerr); end
  endtask

  task automatic test_owed();
    en = 0; step();
    total++; if (cerr !== 1'b0) begin bad++; $display("FAIL owed_off_clears_err got %b want 0", cerr); end
    en = 1; step();
    gnull = 1; step();
    repeat (9) begin space = 1; step(); end
    total++; if (req_s !== 1'b1) begin bad++; $display("FAIL owed_req_high got %b want 1", req_s); end
    space = 1; ack_s = 1; step();
    for (int i = 0; i < 6; i++) begin
      ack_s = 1; step();
      total++; if (req_s !== 1'b1) begin bad++; $display("FAIL owed_req_ack%0d got %b want 1", i, req_s); end
    end
    ack_s = 1; step();
    total++; if (req_s !== 1'b0) begin bad++; $display("FAIL owed_req_last got %b want 0", req_s); end
  endtask

  task automatic test_tick();
    fct = 1; step();
    tick = 1; step();
    total++; if (req_t !== 1'b1) begin bad++; $display("FAIL tick_req got %b want 1", req_t); end
    tick = 1; step();
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL tick_overrun got %b want 1", ovr); end
    step();
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL tick_overrun_pulse got %b want 0", ovr); end
    ack_t = 1; step();
    total++; if (req_t !== 1'b0) begin bad++; $display("FAIL tick_req_after_ack got %b want 0", req_t); end
  endtask

  task automatic test_link_drop();
    fct = 1; step(); fct = 1; step();
    repeat (4) begin ack_d = 1; step(); end
    repeat (3) begin space = 1; step(); end
    tick = 1; step();
    total++; if (cred !== 6'd20) begin bad++; $display("FAIL drop_pre_credit got %0d want 20", cred); end
    total++; if ({req_t, req_s} !== 2'b11) begin bad++; $display("FAIL drop_pre_reqs got %b want 11", {req_t, req_s}); end
    en = 0; step();
    total++; if (st !== 2'd0) begin bad++; $display("FAIL drop_state got %0d want 0", st); end
    total++; if ({req_t, req_s, req_d, req_i} !== 4'b0) begin
      bad++; $display("FAIL drop_reqs got %b want 0000", {req_t, req_s, req_d, req_i});
    end
    total++; if (cred !== 6'd0) begin bad++; $display("FAIL drop_credit got %0d want 0", cred); end
    ack_d = 1; ack_s = 1; ack_t = 1; step();
    total++; if ({pop, cred} !== 7'd0) begin bad++; $display("FAIL drop_ack_ignored got pop=%b credit=%0d want 0/0", pop, cred); end
    en = 1; step(); gnull = 1; step();
    total++; if (req_s !== 1'b0) begin bad++; $display("FAIL drop_owed_cleared got %b want 0", req_s); end
    fct = 1; step();
    total++; if (cred !== 6'd8 || req_t !== 1'b0) begin
      bad++; $display("FAIL drop_rerun got credit=%0d reqTc=%b want 8/0", cred, req_t);
    end
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    logic [1:0]  ms;
    logic [5:0]  mc;
    for (int n = 0; n < 3000; n++) begin
      en     = ($urandom_range(0, 199) != 0);
      gnull  = ($urandom_range(0, 3) == 0);
      fct    = ($urandom_range(0, 4) == 0);
      space  = ($urandom_range(0, 3) == 0);
      tick   = ($urandom_range(0, 5) == 0);
      fempty = ($urandom_range(0, 3) == 0);
      ack_d  = e_reqd && ($urandom_range(0, 1) == 1);
      ack_s  = e_reqs && ($urandom_range(0, 2) == 0);
      ack_t  = e_reqt && ($urandom_range(0, 2) == 0);
      ack_i  = e_reqi && ($urandom_range(0, 1) == 1);
      step();
      ms  = 2'(m_state);
      mc  = 6'(m_credit);
      exp = {ms, mc, (m_err != 0), e_reqt, e_reqs, e_reqd, e_reqi, e_pop, e_ovr};
      got = {st, cred, cerr, req_t, req_s, req_d, req_i, pop, ovr};
      total++; if (got !== exp) begin bad++; $display("FAIL random_cycle%0d got %h want %h", n, got, exp); end
`ifdef TX_LINK_SCHED_STATS_EN
      total++; if (dsent !== 16'(m_dsent) || fsent !== 16'(m_fsent)) begin
        bad++; $display("FAIL random_stats%0d got %0d/%0d want %0d/%0d", n, dsent, fsent, m_dsent, m_fsent);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_data_drain();
    test_credit_overflow();
    test_owed();
    test_tick();
    test_link_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
